memory_stage: RTL and testbench

- Pipeline MEM stage, downstream end of the execute-to-memory payload interface.
- Accepts one instruction at a time from execute (instr, control, ALU result, store data, rd, pc+4).
- Performs loads/stores on a req/gnt/rvalid data-memory port, with byte-lane steering and load sign/zero extension.
- Presents a registered result to writeback with valid/ready; backpressures execute through exe_ready_o.

---
 rtl/memory_stage.sv | 240 ++++++++++++++++++++++++
 tb/tb_memory_stage.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
//  Module   : memory_stage
//  Purpose  : Pipeline MEM stage. Accepts one payload from execute, performs
//             byte-lane-steered loads/stores over a req/gnt/rvalid port and
//             presents a registered, handshaked result to writeback.
//  Revision : 1.0  initial release
// ============================================================================
`ifndef CONTROL_BIT
`define CONTROL_BIT 8
`endif

module memory_stage #(
    parameter int          CONTROL_W = `CONTROL_BIT,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 exe_valid_i,
    input  logic [31:0]          exe_instr_i,
    input  logic [CONTROL_W-1:0] exe_control_i,
    input  logic [31:0]          exe_aluResult_i,
    input  logic [31:0]          exe_data_i,
    input  logic [4:0]           exe_rd_addr_i,
    input  logic [31:0]          exe_pcplus_i,
    output logic                 exe_ready_o,
    output logic                 dmem_req_o,
    output logic                 dmem_we_o,
    output logic [31:0]          dmem_addr_o,
    output logic [3:0]           dmem_be_o,
    output logic [31:0]          dmem_wdata_o,
    input  logic                 dmem_gnt_i,
    input  logic                 dmem_rvalid_i,
    input  logic [31:0]          dmem_rdata_i,
    output logic                 wb_valid_o,
    output logic [31:0]          wb_instr_o,
    output logic [CONTROL_W-1:0] wb_control_o,
    output logic [31:0]          wb_result_o,
    output logic [4:0]           wb_rd_addr_o,
    output logic [31:0]          wb_pcplus_o,
    output logic                 wb_misalign_o,
    input  logic                 wb_ready_i
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // funct3[1:0] encodes access size: 00 byte, 01 half, 10 word
    function automatic logic [3:0] lanes(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   lanes = 4'b0001 << off;
            2'b01:   lanes = 4'b0011 << off;
            default: lanes = 4'b1111;
        endcase
    endfunction

    state_t                 state_q, state_d;
    logic [31:0]            acc_instr_q, acc_instr_d;
    logic [CONTROL_W-1:0]   acc_control_q, acc_control_d;
    logic [31:0]            acc_addr_q, acc_addr_d;
    logic [31:0]            acc_data_q, acc_data_d;
    logic [4:0]             acc_rd_q, acc_rd_d;
    logic [31:0]            acc_pcplus_q, acc_pcplus_d;
    logic                   wb_valid_q, wb_valid_d;
    logic [31:0]            wb_instr_q, wb_instr_d;
    logic [CONTROL_W-1:0]   wb_control_q, wb_control_d;
    logic [31:0]            wb_result_q, wb_result_d;
    logic [4:0]             wb_rd_q, wb_rd_d;
    logic [31:0]            wb_pcplus_q, wb_pcplus_d;
    logic                   wb_misalign_q, wb_misalign_d;

    // Incoming payload decode
    logic [2:0] in_f3;
    logic [1:0] in_off;
    logic       in_is_load, in_is_store, in_is_mem, in_legal, in_mis, in_access_ok, xfer;
    // Latched access decode
    logic [2:0] acc_f3;
    logic [1:0] acc_off;
    logic       acc_store;
    logic [7:0] ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign in_f3        = exe_instr_i[14:12];
    assign in_off       = exe_aluResult_i[1:0];
    assign in_is_load   = (exe_instr_i[6:0] == OP_LOAD);
    assign in_is_store  = (exe_instr_i[6:0] == OP_STORE);
    assign in_is_mem    = in_is_load || in_is_store;
    assign in_legal     = in_is_load  ? (in_f3 != 3'b011 && in_f3 != 3'b110 && in_f3 != 3'b111)
                        : in_is_store ? (in_f3[2] == 1'b0 && in_f3[1:0] != 2'b11)
                        : 1'b0;
    assign in_mis       = (in_f3[1:0] == 2'b01) ? in_off[0]
                        : (in_f3[1:0] == 2'b10) ? (in_off != 2'b00)
                        : 1'b0;
    assign in_access_ok = in_legal && !in_mis;

    assign exe_ready_o  = (state_q == IDLE) && (!wb_valid_q || wb_ready_i);
    assign xfer         = exe_valid_i && exe_ready_o;

    assign acc_f3    = acc_instr_q[14:12];
    assign acc_off   = acc_addr_q[1:0];
    assign acc_store = (acc_instr_q[6:0] == OP_STORE);

    // Memory port is only driven while a request is outstanding
    assign dmem_req_o   = (state_q == REQ);
    assign dmem_we_o    = dmem_req_o && acc_store;
    assign dmem_addr_o  = dmem_req_o ? {acc_addr_q[31:2], 2'b00} : 32'd0;
    assign dmem_be_o    = dmem_req_o ? lanes(acc_f3[1:0], acc_off) : 4'd0;
    assign dmem_wdata_o = !dmem_we_o              ? 32'd0
                        : (acc_f3[1:0] == 2'b00)  ? {4{acc_data_q[7:0]}}
                        : (acc_f3[1:0] == 2'b01)  ? {2{acc_data_q[15:0]}}
                        : acc_data_q;

    // Load data extraction; halfword accesses are aligned so off[1] picks the half
    assign ld_byte = dmem_rdata_i[{acc_off, 3'b000} +: 8];
    assign ld_half = dmem_rdata_i[{acc_off[1], 4'b0000} +: 16];
    always_comb begin
        case (acc_f3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = dmem_rdata_i;
        endcase
    end

    // Next-state logic for the FSM, access latch and writeback register
    always_comb begin
        state_d       = state_q;
        acc_instr_d   = acc_instr_q;
        acc_control_d = acc_control_q;
        acc_addr_d    = acc_addr_q;
        acc_data_d    = acc_data_q;
        acc_rd_d      = acc_rd_q;
        acc_pcplus_d  = acc_pcplus_q;
        wb_valid_d    = wb_valid_q && !wb_ready_i;
        wb_instr_d    = wb_instr_q;
        wb_control_d  = wb_control_q;
        wb_result_d   = wb_result_q;
        wb_rd_d       = wb_rd_q;
        wb_pcplus_d   = wb_pcplus_q;
        wb_misalign_d = wb_misalign_q;
        case (state_q)
            IDLE: begin
                if (xfer && in_access_ok) begin
                    state_d       = REQ;
                    acc_instr_d   = exe_instr_i;
                    acc_control_d = exe_control_i;
                    acc_addr_d    = exe_aluResult_i;
                    acc_data_d    = exe_data_i;
                    acc_rd_d      = exe_rd_addr_i;
                    acc_pcplus_d  = exe_pcplus_i;
                end else if (xfer) begin
                    wb_valid_d    = 1'b1;
                    wb_instr_d    = exe_instr_i;
                    wb_control_d  = exe_control_i;
                    wb_result_d   = exe_aluResult_i;
                    wb_rd_d       = exe_rd_addr_i;
                    wb_pcplus_d   = exe_pcplus_i;
                    wb_misalign_d = in_is_mem;
                end
            end
            REQ: begin
                if (dmem_gnt_i) begin
                    state_d = acc_store ? IDLE : WAIT;
                    if (acc_store) begin
                        wb_valid_d    = 1'b1;
                        wb_instr_d    = acc_instr_q;
                        wb_control_d  = acc_control_q;
                        wb_result_d   = acc_addr_q;
                        wb_rd_d       = acc_rd_q;
                        wb_pcplus_d   = acc_pcplus_q;
                        wb_misalign_d = 1'b0;
                    end
                end
            end
            WAIT: begin
                if (dmem_rvalid_i) begin
                    state_d       = IDLE;
                    wb_valid_d    = 1'b1;
                    wb_instr_d    = acc_instr_q;
                    wb_control_d  = acc_control_q;
                    wb_result_d   = ld_data;
                    wb_rd_d       = acc_rd_q;
                    wb_pcplus_d   = acc_pcplus_q;
                    wb_misalign_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and data registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            acc_instr_q   <= 32'd0;
            acc_control_q <= '0;
            acc_addr_q    <= 32'd0;
            acc_data_q    <= 32'd0;
            acc_rd_q      <= 5'd0;
            acc_pcplus_q  <= 32'd0;
            wb_valid_q    <= 1'b0;
            wb_instr_q    <= NOP_INSTR;
            wb_control_q  <= '0;
            wb_result_q   <= 32'd0;
            wb_rd_q       <= 5'd0;
            wb_pcplus_q   <= 32'd0;
            wb_misalign_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_instr_q   <= acc_instr_d;
            acc_control_q <= acc_control_d;
            acc_addr_q    <= acc_addr_d;
            acc_data_q    <= acc_data_d;
            acc_rd_q      <= acc_rd_d;
            acc_pcplus_q  <= acc_pcplus_d;
            wb_valid_q    <= wb_valid_d;
            wb_instr_q    <= wb_instr_d;
            wb_control_q  <= wb_control_d;
            wb_result_q   <= wb_result_d;
            wb_rd_q       <= wb_rd_d;
            wb_pcplus_q   <= wb_pcplus_d;
            wb_misalign_q <= wb_misalign_d;
        end
    end

    assign wb_valid_o    = wb_valid_q;
    assign wb_instr_o    = wb_instr_q;
    assign wb_control_o  = wb_control_q;
    assign wb_result_o   = wb_result_q;
    assign wb_rd_addr_o  = wb_rd_q;
    assign wb_pcplus_o   = wb_pcplus_q;
    assign wb_misalign_o = wb_misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_memory_stage
//  Purpose  : Self-checking bench for memory_stage: directed scenarios plus
//             randomized loads/stores/ALU ops against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_memory_stage;
    localparam int          CW  = 8;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          exe_valid_i = 1'b0;
    logic [31:0]   exe_instr_i = '0, exe_aluResult_i = '0, exe_data_i = '0, exe_pcplus_i = '0;
    logic [CW-1:0] exe_control_i = '0;
    logic [4:0]    exe_rd_addr_i = '0;
    logic          exe_ready_o;
    logic          dmem_req_o, dmem_we_o;
    logic [31:0]   dmem_addr_o, dmem_wdata_o;
    logic [3:0]    dmem_be_o;
    logic          dmem_gnt_i = 1'b0, dmem_rvalid_i = 1'b0;
    logic [31:0]   dmem_rdata_i = '0;
    logic          wb_valid_o, wb_misalign_o;
    logic [31:0]   wb_instr_o, wb_result_o, wb_pcplus_o;
    logic [CW-1:0] wb_control_o;
    logic [4:0]    wb_rd_addr_o;
    logic          wb_ready_i = 1'b1;

    memory_stage #(.CONTROL_W(CW), .NOP_INSTR(NOP)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .exe_valid_i(exe_valid_i), .exe_instr_i(exe_instr_i), .exe_control_i(exe_control_i),
        .exe_aluResult_i(exe_aluResult_i), .exe_data_i(exe_data_i), .exe_rd_addr_i(exe_rd_addr_i),
        .exe_pcplus_i(exe_pcplus_i), .exe_ready_o(exe_ready_o),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_instr_o(wb_instr_o), .wb_control_o(wb_control_o),
        .wb_result_o(wb_result_o), .wb_rd_addr_o(wb_rd_addr_o), .wb_pcplus_o(wb_pcplus_o),
        .wb_misalign_o(wb_misalign_o), .wb_ready_i(wb_ready_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Observations captured by run_op
    bit            ob_accept_ready, ob_req_seen, ob_we, ob_mis;
    int            ob_unstable, ob_busy_ready, ob_lat;
    logic [3:0]    ob_be;
    logic [31:0]   ob_addr, ob_wdata, ob_res, ob_instr, ob_pcplus;
    logic [4:0]    ob_rd;
    logic [CW-1:0] ob_ctl;

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] op);
        return {12'h0A5, 5'd3, f3, 5'd7, op};
    endfunction

    // Reference model: what the access should look like, from the ISA rules
    task automatic model(input logic [31:0] instr, addr, data, rdata,
                         output bit acc, output bit mis, output bit we,
                         output logic [3:0] be, output logic [31:0] wdata, output logic [31:0] res);
        int f3, nb, off;
        bit isl, iss, legal;
        longint v;
        f3  = int'(instr[14:12]);
        off = int'(addr[1:0]);
        isl = (instr[6:0] == 7'b0000011);
        iss = (instr[6:0] == 7'b0100011);
        legal = isl ? (f3 inside {0, 1, 2, 4, 5}) : iss ? (f3 inside {0, 1, 2}) : 1'b0;
        nb  = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        acc = legal && (off % nb == 0);
        mis = (isl || iss) && !acc;
        we  = acc && iss;
        be = '0; wdata = '0; res = addr;
        if (acc) begin
            for (int i = 0; i < 4; i++) begin
                be[i] = (i >= off) && (i < off + nb);
                if (iss) wdata[8*i +: 8] = data[8*(i % nb) +: 8];
            end
            if (isl) begin
                v = 0;
                for (int j = 0; j < nb; j++) v += longint'(rdata[8*(off+j) +: 8]) << (8*j);
                if (f3 < 4 && nb < 4 && v >= (longint'(1) << (8*nb-1))) v -= (longint'(1) << (8*nb));
                res = 32'(v);
            end
        end
    endtask

    // Drives one payload (wb_ready_i=1), acts as memory, records what happens
    task automatic run_op(input logic [31:0] instr, addr, data, rdata, input logic [CW-1:0] ctl,
                          input logic [4:0] rd, input logic [31:0] pcp, input int gdly, input int rdly);
        int reqc, wcnt;
        bit granted;
        @(negedge clk_i);
        exe_valid_i = 1'b1; exe_instr_i = instr; exe_aluResult_i = addr; exe_data_i = data;
        exe_control_i = ctl; exe_rd_addr_i = rd; exe_pcplus_i = pcp;
        wb_ready_i = 1'b1; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
        #1;
        ob_accept_ready = exe_ready_o;
        ob_req_seen = 0; ob_unstable = 0; ob_busy_ready = 0; ob_lat = -1;
        reqc = 0; wcnt = 0; granted = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk_i);
            exe_valid_i = 1'b0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = $urandom;
            #1;
            if (wb_valid_o) begin
                ob_lat = k; ob_res = wb_result_o; ob_mis = wb_misalign_o; ob_instr = wb_instr_o;
                ob_rd = wb_rd_addr_o; ob_pcplus = wb_pcplus_o; ob_ctl = wb_control_o;
                break;
            end
            if (exe_ready_o) ob_busy_ready++;
            if (dmem_req_o) begin
                if (!ob_req_seen) begin
                    ob_addr = dmem_addr_o; ob_be = dmem_be_o; ob_wdata = dmem_wdata_o; ob_we = dmem_we_o;
                end else if (dmem_addr_o !== ob_addr || dmem_be_o !== ob_be ||
                             dmem_wdata_o !== ob_wdata || dmem_we_o !== ob_we) ob_unstable++;
                ob_req_seen = 1;
                if (reqc == gdly) begin dmem_gnt_i = 1'b1; granted = 1; end
                else dmem_rvalid_i = 1'($urandom % 2);
                reqc++;
            end else if (granted) begin
                if (wcnt == rdly) begin dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata; end
                dmem_gnt_i = 1'($urandom % 2);
                wcnt++;
            end else begin
                dmem_rvalid_i = 1'($urandom % 2);
            end
        end
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        #1;
        checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid_o); end
        checks++; if (wb_instr_o !== NOP) begin errors++; $display("FAIL reset_wb_instr: got %h want %h", wb_instr_o, NOP); end
        checks++; if (dmem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", dmem_req_o); end
        checks++; if (wb_result_o !== 32'd0 || wb_misalign_o !== 1'b0) begin errors++; $display("FAIL reset_wb_data: got %h/%b want 0/0", wb_result_o, wb_misalign_o); end
        @(negedge clk_i); rst_i = 1'b0; #1;
        checks++; if (exe_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", exe_ready_o); end
    endtask

    task automatic test_passthrough();
        logic [31:0] res [3], ins [3], r;
        wb_ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            if (c < 3) begin
                r = $urandom; ins[c] = {r[31:7], 7'b0110011}; res[c] = $urandom;
                exe_valid_i = 1'b1; exe_instr_i = ins[c]; exe_aluResult_i = res[c];
            end else exe_valid_i = 1'b0;
            #1;
            if (c > 0) begin
                checks++; if (wb_valid_o !== 1'b1 || wb_result_o !== res[c-1] || wb_instr_o !== ins[c-1])
                    begin errors++; $display("FAIL pass_wb[%0d]: got v=%b r=%h want v=1 r=%h", c-1, wb_valid_o, wb_result_o, res[c-1]); end
            end
            if (c < 3) begin
                checks++; if (exe_ready_o !== 1'b1) begin errors++; $display("FAIL pass_ready[%0d]: got %b want 1", c, exe_ready_o); end
            end
        end
        @(negedge clk_i); #1;
        checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL pass_drain: got %b want 0", wb_valid_o); end
    endtask

    task automatic test_load();
        run_op(mk(3'b000, 7'b0000011), 32'h1003, 32'h0, 32'h80FF_0000, 8'h11, 5'd7, 32'h100, 0, 0);
        checks++; if (ob_addr !== 32'h1000) begin errors++; $display("FAIL lb_addr: got %h want 00001000", ob_addr); end
        checks++; if (ob_be !== 4'b1000) begin errors++; $display("FAIL lb_be: got %b want 1000", ob_be); end
        checks++; if (ob_lat !== 3) begin errors++; $display("FAIL lb_latency: got %0d want 3", ob_lat); end
        checks++; if (ob_res !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_result: got %h want ffffff80", ob_res); end
        run_op(mk(3'b100, 7'b0000011), 32'h1003, 32'h0, 32'h80FF_0000, 8'h11, 5'd7, 32'h100, 0, 0);
        checks++; if (ob_res !== 32'h0000_0080) begin errors++; $display("FAIL lbu_result: got %h want 00000080", ob_res); end
    endtask

    task automatic test_store();
        run_op(mk(3'b001, 7'b0100011), 32'h2002, 32'h1234_ABCD, 32'h0, 8'h22, 5'd0, 32'h204, 3, 0);
        checks++; if (ob_be !== 4'b1100 || ob_we !== 1'b1) begin errors++; $display("FAIL sh_be_we: got %b/%b want 1100/1", ob_be, ob_we); end
        checks++; if (ob_wdata !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_wdata: got %h want abcdabcd", ob_wdata); end
        checks++; if (ob_unstable !== 0) begin errors++; $display("FAIL sh_stable: got %0d changes want 0", ob_unstable); end
        checks++; if (ob_busy_ready !== 0) begin errors++; $display("FAIL sh_ready_low: got %0d ready cycles want 0", ob_busy_ready); end
        checks++; if (ob_lat !== 5 || ob_res !== 32'h2002) begin errors++; $display("FAIL sh_wb: got lat %0d res %h want 5 00002002", ob_lat, ob_res); end
    endtask

    task automatic test_misalign();
        run_op(mk(3'b010, 7'b0000011), 32'h3001, 32'h0, 32'h0, 8'h33, 5'd1, 32'h300, 0, 0);
        checks++; if (ob_req_seen !== 1'b0) begin errors++; $display("FAIL lw_mis_noreq: got req %b want 0", ob_req_seen); end
        checks++; if (ob_lat !== 1 || ob_mis !== 1'b1 || ob_res !== 32'h3001)
            begin errors++; $display("FAIL lw_mis_wb: got lat %0d mis %b res %h want 1 1 00003001", ob_lat, ob_mis, ob_res); end
        run_op(mk(3'b011, 7'b0000011), 32'h3000, 32'h0, 32'h0, 8'h33, 5'd1, 32'h300, 0, 0);
        checks++; if (ob_req_seen !== 1'b0 || ob_mis !== 1'b1) begin errors++; $display("FAIL ld_illegal: got req %b mis %b want 0 1", ob_req_seen, ob_mis); end
    endtask

    task automatic test_backpressure();
        @(negedge clk_i);
        wb_ready_i = 1'b0; exe_valid_i = 1'b1; exe_instr_i = mk(3'b000, 7'b0010011); exe_aluResult_i = 32'hAAAA_0001;
        @(negedge clk_i);
        exe_instr_i = mk(3'b111, 7'b0110011); exe_aluResult_i = 32'hBBBB_0002;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk_i);
            #1;
            checks++; if (wb_valid_o !== 1'b1 || wb_result_o !== 32'hAAAA_0001 || exe_ready_o !== 1'b0)
                begin errors++; $display("FAIL bp_hold[%0d]: got v=%b r=%h rdy=%b want 1 aaaa0001 0", c, wb_valid_o, wb_result_o, exe_ready_o); end
        end
        @(negedge clk_i); wb_ready_i = 1'b1; #1;
        checks++; if (exe_ready_o !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", exe_ready_o); end
        @(negedge clk_i); exe_valid_i = 1'b0; #1;
        checks++; if (wb_valid_o !== 1'b1 || wb_result_o !== 32'hBBBB_0002)
            begin errors++; $display("FAIL bp_next: got v=%b r=%h want 1 bbbb0002", wb_valid_o, wb_result_o); end
        @(negedge clk_i); #1;
        checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", wb_valid_o); end
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk_i);
        wb_ready_i = 1'b1; exe_valid_i = 1'b1; exe_instr_i = mk(3'b010, 7'b0000011); exe_aluResult_i = 32'h4000;
        @(negedge clk_i); exe_valid_i = 1'b0; #1;
        checks++; if (dmem_req_o !== 1'b1) begin errors++; $display("FAIL rw_req: got %b want 1", dmem_req_o); end
        dmem_gnt_i = 1'b1;
        @(negedge clk_i); dmem_gnt_i = 1'b0; #1;
        checks++; if (dmem_req_o !== 1'b0 || wb_valid_o !== 1'b0) begin errors++; $display("FAIL rw_wait: got req %b v %b want 0 0", dmem_req_o, wb_valid_o); end
        rst_i = 1'b1;
        @(negedge clk_i); rst_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF; #1;
        checks++; if (dmem_req_o !== 1'b0 || wb_valid_o !== 1'b0 || wb_instr_o !== NOP || exe_ready_o !== 1'b1)
            begin errors++; $display("FAIL rw_reset: got req %b v %b instr %h rdy %b want 0 0 %h 1", dmem_req_o, wb_valid_o, wb_instr_o, exe_ready_o, NOP); end
        @(negedge clk_i); dmem_rvalid_i = 1'b0; #1;
        checks++; if (wb_valid_o !== 1'b0 || wb_result_o !== 32'd0) begin errors++; $display("FAIL rw_rvalid_ignored: got v %b r %h want 0 0", wb_valid_o, wb_result_o); end
    endtask

    task automatic test_random();
        logic [31:0] instr, addr, data, rdata, pcp, r, e_wdata, e_res;
        logic [CW-1:0] ctl;
        logic [4:0] rd;
        logic [3:0] e_be;
        logic [6:0] op;
        bit e_acc, e_mis, e_we;
        int gd, rdl, e_lat;
        for (int n = 0; n < 80; n++) begin
            r = $urandom;
            case ($urandom % 3)
                0: op = 7'b0000011;
                1: op = 7'b0100011;
                default: op = (r[6:0] == 7'b0000011 || r[6:0] == 7'b0100011) ? 7'b0110011 : r[6:0];
            endcase
            instr = {r[31:7], op};
            addr = $urandom; data = $urandom; rdata = $urandom; pcp = $urandom;
            r = $urandom; ctl = r[CW-1:0]; rd = r[12:8];
            gd = int'($urandom % 3); rdl = int'($urandom % 3);
            model(instr, addr, data, rdata, e_acc, e_mis, e_we, e_be, e_wdata, e_res);
            e_lat = !e_acc ? 1 : e_we ? 2 + gd : 3 + gd + rdl;
            run_op(instr, addr, data, rdata, ctl, rd, pcp, gd, rdl);
            checks++; if (ob_accept_ready !== 1'b1) begin errors++; $display("FAIL rnd%0d_accept: got %b want 1", n, ob_accept_ready); end
            checks++; if (ob_lat !== e_lat) begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", n, ob_lat, e_lat); end
            checks++; if (ob_res !== e_res || ob_mis !== e_mis) begin errors++; $display("FAIL rnd%0d_result: got %h mis %b want %h mis %b", n, ob_res, ob_mis, e_res, e_mis); end
            checks++; if (ob_instr !== instr || ob_rd !== rd || ob_pcplus !== pcp || ob_ctl !== ctl)
                begin errors++; $display("FAIL rnd%0d_payload: got %h %0d %h %h want %h %0d %h %h", n, ob_instr, ob_rd, ob_pcplus, ob_ctl, instr, rd, pcp, ctl); end
            checks++; if (ob_req_seen !== e_acc) begin errors++; $display("FAIL rnd%0d_req: got %b want %b", n, ob_req_seen, e_acc); end
            if (e_acc) begin
                checks++; if (ob_addr !== {addr[31:2], 2'b00} || ob_be !== e_be || ob_we !== e_we || ob_wdata !== e_wdata)
                    begin errors++; $display("FAIL rnd%0d_dmem: got %h %b %b %h want %h %b %b %h", n, ob_addr, ob_be, ob_we, ob_wdata, {addr[31:2], 2'b00}, e_be, e_we, e_wdata); end
                checks++; if (ob_unstable !== 0 || ob_busy_ready !== 0)
                    begin errors++; $display("FAIL rnd%0d_hold: got %0d changes %0d ready want 0 0", n, ob_unstable, ob_busy_ready); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load();
        test_store();
        test_misalign();
        test_backpressure();
        test_reset_in_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
